// File: rtl/uart_lite_pkg.sv
// Shared definitions for the AXI UART Lite responder: register map, STAT/CTRL bits, responses.
package uart_lite_pkg;

   localparam logic [1:0] REG_RX   = 2'd0;
   localparam logic [1:0] REG_TX   = 2'd1;
   localparam logic [1:0] REG_STAT = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   localparam int unsigned STAT_RX_VALID = 0;
   localparam int unsigned STAT_RX_FULL  = 1;
   localparam int unsigned STAT_TX_EMPTY = 2;
   localparam int unsigned STAT_TX_FULL  = 3;
   localparam int unsigned STAT_INTR_EN  = 4;
   localparam int unsigned STAT_OVERRUN  = 5;
   localparam int unsigned STAT_W        = 6;

   localparam int unsigned CTRL_TX_CLR  = 0;
   localparam int unsigned CTRL_RX_CLR  = 1;
   localparam int unsigned CTRL_INTR_EN = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flow-through head; clear has priority over push and pop.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   input  logic             clear,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic             last
);

   localparam int unsigned PTRW = $clog2(DEPTH);
   localparam logic [PTRW:0] COUNT_FULL = (PTRW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTRW:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == COUNT_FULL);
      last    = (count_q == (PTRW+1)'(1));
      // Head reads as zero when empty so the line side never sees stale bytes.
      dout    = empty ? '0 : mem_q[rd_ptr_q];
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q + PTRW'(do_push);
      rd_ptr_d = rd_ptr_q + PTRW'(do_pop);
      count_d  = count_q + (PTRW+1)'(do_push) - (PTRW+1)'(do_pop);
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/axi_uart_lite_responder.sv
// AXI4-Lite responder presenting the UART Lite register map over byte-wide RX/TX FIFOs.
module axi_uart_lite_responder
   import uart_lite_pkg::*;
#(
   parameter int unsigned AXI_DATAW      = 32,
   parameter int unsigned AXI_DATAW_BYTE = 4,
   parameter int unsigned AXI_ADDRW      = 32,
   parameter int unsigned FIFO_DEPTH     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [AXI_ADDRW-1:0]      awaddr,
   input  logic [2:0]                awprot,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [AXI_DATAW-1:0]      wdata,
   input  logic [AXI_DATAW_BYTE-1:0] wstrb,
   input  logic                      wvalid,
   output logic                      wready,
   output logic [1:0]                bresp,
   output logic                      bvalid,
   input  logic                      bready,
   input  logic [AXI_ADDRW-1:0]      araddr,
   input  logic [2:0]                arprot,
   input  logic                      arvalid,
   output logic                      arready,
   output logic [AXI_DATAW-1:0]      rdata,
   output logic [1:0]                rresp,
   output logic                      rvalid,
   input  logic                      rready,
   input  logic                      rx_valid,
   input  logic [7:0]                rx_data,
   output logic                      tx_valid,
   output logic [7:0]                tx_data,
   input  logic                      tx_ready,
   output logic                      interrupt
);

   logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [1:0] wr_reg_q, wr_reg_d;
   logic [7:0] wr_byte_q, wr_byte_d;
   logic wr_strb0_q, wr_strb0_d;
   logic arready_q, arready_d, rvalid_q, rvalid_d;
   logic [AXI_DATAW-1:0] rdata_q, rdata_d;
   logic intr_en_q, intr_en_d, overrun_q, overrun_d, interrupt_q, interrupt_d;

   logic rx_empty, rx_full, rx_last, tx_empty, tx_full, tx_last;
   logic [7:0] rx_dout, tx_dout;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_exec, ctrl_wr;
   logic tx_push, tx_pop, tx_clear, rx_pop, rx_clear;
   logic [1:0] rd_reg;
   logic [STAT_W-1:0] stat;

   always_comb begin
      aw_hs    = awvalid && awready_q;
      w_hs     = wvalid && wready_q;
      b_hs     = bvalid_q && bready;
      ar_hs    = arvalid && arready_q;
      r_hs     = rvalid_q && rready;
      rd_reg   = araddr[3:2];
      wr_exec  = aw_held_q && w_held_q;
      ctrl_wr  = wr_exec && wr_strb0_q && (wr_reg_q == REG_CTRL);
      tx_push  = wr_exec && wr_strb0_q && (wr_reg_q == REG_TX);
      tx_clear = ctrl_wr && wr_byte_q[CTRL_TX_CLR];
      rx_clear = ctrl_wr && wr_byte_q[CTRL_RX_CLR];
      tx_pop   = tx_ready && !tx_empty;
      rx_pop   = ar_hs && (rd_reg == REG_RX);

      stat                = '0;
      stat[STAT_RX_VALID] = !rx_empty;
      stat[STAT_RX_FULL]  = rx_full;
      stat[STAT_TX_EMPTY] = tx_empty;
      stat[STAT_TX_FULL]  = tx_full;
      stat[STAT_INTR_EN]  = intr_en_q;
      stat[STAT_OVERRUN]  = overrun_q;
   end

   always_comb begin
      awready_d   = awready_q;
      wready_d    = wready_q;
      bvalid_d    = bvalid_q;
      aw_held_d   = aw_held_q;
      w_held_d    = w_held_q;
      wr_reg_d    = wr_reg_q;
      wr_byte_d   = wr_byte_q;
      wr_strb0_d  = wr_strb0_q;
      arready_d   = arready_q;
      rvalid_d    = rvalid_q;
      rdata_d     = rdata_q;
      intr_en_d   = intr_en_q;
      overrun_d   = overrun_q;

      if (aw_hs) begin
         awready_d = 1'b0;
         aw_held_d = 1'b1;
         wr_reg_d  = awaddr[3:2];
      end
      if (w_hs) begin
         wready_d   = 1'b0;
         w_held_d   = 1'b1;
         wr_byte_d  = wdata[7:0];
         wr_strb0_d = wstrb[0];
      end
      if (wr_exec) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
      end
      if (b_hs) begin
         bvalid_d  = 1'b0;
         awready_d = 1'b1;
         wready_d  = 1'b1;
      end

      if (ar_hs) begin
         arready_d = 1'b0;
         rvalid_d  = 1'b1;
         rdata_d   = '0;
         case (rd_reg)
            REG_RX:   rdata_d[7:0] = rx_dout;
            REG_STAT: rdata_d[STAT_W-1:0] = stat;
            default:  rdata_d = '0;
         endcase
      end
      if (r_hs) begin
         rvalid_d  = 1'b0;
         arready_d = 1'b1;
      end

      if (ctrl_wr) intr_en_d = wr_byte_q[CTRL_INTR_EN];
      // A fresh overrun in the same cycle as a STAT read survives for the next read.
      if (ar_hs && (rd_reg == REG_STAT)) overrun_d = 1'b0;
      if (rx_valid && rx_full && !rx_pop) overrun_d = 1'b1;
      if (rx_clear) overrun_d = 1'b0;

      interrupt_d = intr_en_q &&
                    ((rx_empty && rx_valid && !rx_clear) ||
                     (tx_pop && tx_last && !tx_push && !tx_clear));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         awready_q   <= 1'b1;
         wready_q    <= 1'b1;
         bvalid_q    <= 1'b0;
         aw_held_q   <= 1'b0;
         w_held_q    <= 1'b0;
         wr_reg_q    <= '0;
         wr_byte_q   <= '0;
         wr_strb0_q  <= 1'b0;
         arready_q   <= 1'b1;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         intr_en_q   <= 1'b0;
         overrun_q   <= 1'b0;
         interrupt_q <= 1'b0;
      end else begin
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         bvalid_q    <= bvalid_d;
         aw_held_q   <= aw_held_d;
         w_held_q    <= w_held_d;
         wr_reg_q    <= wr_reg_d;
         wr_byte_q   <= wr_byte_d;
         wr_strb0_q  <= wr_strb0_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         intr_en_q   <= intr_en_d;
         overrun_q   <= overrun_d;
         interrupt_q <= interrupt_d;
      end
   end

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_valid),
      .din   (rx_data),
      .pop   (rx_pop),
      .clear (rx_clear),
      .dout  (rx_dout),
      .empty (rx_empty),
      .full  (rx_full),
      .last  (rx_last)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .din   (wr_byte_q),
      .pop   (tx_pop),
      .clear (tx_clear),
      .dout  (tx_dout),
      .empty (tx_empty),
      .full  (tx_full),
      .last  (tx_last)
   );

   assign awready   = awready_q;
   assign wready    = wready_q;
   assign bvalid    = bvalid_q;
   assign bresp     = RESP_OKAY;
   assign arready   = arready_q;
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign rresp     = RESP_OKAY;
   assign tx_valid  = !tx_empty;
   assign tx_data   = tx_dout;
   assign interrupt = interrupt_q;

   // Address bits outside [3:2], upper data lanes and prot are don't-care by design.
   logic unused_bits;
   assign unused_bits = ^{awaddr[AXI_ADDRW-1:4], awaddr[1:0], araddr[AXI_ADDRW-1:4], araddr[1:0],
                          wdata[AXI_DATAW-1:8], wstrb[AXI_DATAW_BYTE-1:1], awprot, arprot,
                          rx_last};

endmodule

// File: tb/tb_axi_uart_lite_responder.sv
// Self-checking bench: directed scenarios plus a randomized mix against a queue-based model.
module tb_axi_uart_lite_responder;

   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic        rx_valid, tx_valid, tx_ready, interrupt;
   logic [7:0]  rx_data, tx_data;

   int n_cmp = 0;
   int n_err = 0;
   int irq_total = 0;

   byte unsigned rx_m[$];
   byte unsigned tx_m[$];
   bit ovr_m = 1'b0;
   bit ien_m = 1'b0;

   axi_uart_lite_responder #(
      .AXI_DATAW(32), .AXI_DATAW_BYTE(4), .AXI_ADDRW(32), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (interrupt === 1'b1) irq_total++;

   // ---------------- reference model ----------------
   function automatic logic [31:0] exp_stat();
      logic [31:0] s;
      s = '0;
      s[0] = (rx_m.size() != 0);
      s[1] = (rx_m.size() == DEPTH);
      s[2] = (tx_m.size() == 0);
      s[3] = (tx_m.size() == DEPTH);
      s[4] = ien_m;
      s[5] = ovr_m;
      return s;
   endfunction

   function automatic void m_rx_push(input byte unsigned b);
      if (rx_m.size() < DEPTH) rx_m.push_back(b);
      else ovr_m = 1'b1;
   endfunction

   function automatic void m_write(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [3:0] strb);
      if (!strb[0]) return;
      case (addr[3:2])
         2'd1: if (tx_m.size() < DEPTH) tx_m.push_back(data[7:0]);
         2'd3: begin
            if (data[0]) tx_m.delete();
            if (data[1]) begin rx_m.delete(); ovr_m = 1'b0; end
            ien_m = data[4];
         end
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] addr);
      logic [31:0] v;
      v = '0;
      case (addr[3:2])
         2'd0: if (rx_m.size() != 0) v[7:0] = rx_m.pop_front();
         2'd2: begin v = exp_stat(); ovr_m = 1'b0; end
         default: ;
      endcase
      return v;
   endfunction

   function automatic void m_reset();
      rx_m.delete(); tx_m.delete(); ovr_m = 1'b0; ien_m = 1'b0;
   endfunction

   // ---------------- bus drivers ----------------
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, input int bwait,
                            output logic [1:0] resp, output bit ok, output int held);
      bit aw_pend, w_pend, aw_hs, w_hs;
      int c;
      ok = 1'b1; held = 0; resp = 2'bxx;
      awaddr = addr; wdata = data; wstrb = strb; bready = 1'b0;
      aw_pend = 1'b1; w_pend = 1'b1; c = 0;
      while ((aw_pend || w_pend) && c < 50) begin
         awvalid = aw_pend;
         wvalid  = w_pend && (c >= lead);
         aw_hs   = awvalid && (awready === 1'b1);
         w_hs    = wvalid && (wready === 1'b1);
         @(negedge clk);
         if (aw_hs) aw_pend = 1'b0;
         if (w_hs) w_pend = 1'b0;
         c++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (aw_pend || w_pend) begin ok = 1'b0; return; end
      c = 0;
      while (bvalid !== 1'b1 && c < 20) begin @(negedge clk); c++; end
      if (bvalid !== 1'b1) begin ok = 1'b0; return; end
      repeat (bwait) begin
         if (bvalid === 1'b1) held++;
         @(negedge clk);
      end
      resp = bresp; bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit ok);
      int c;
      ok = 1'b1; data = 'x; resp = 2'bxx; c = 0;
      araddr = addr; arvalid = 1'b1;
      while (arready !== 1'b1 && c < 20) begin @(negedge clk); c++; end
      if (arready !== 1'b1) begin arvalid = 1'b0; ok = 1'b0; return; end
      @(negedge clk);
      arvalid = 1'b0; c = 0;
      while (rvalid !== 1'b1 && c < 20) begin @(negedge clk); c++; end
      if (rvalid !== 1'b1) begin ok = 1'b0; return; end
      data = rdata; resp = rresp; rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic rx_push(input byte unsigned b);
      rx_valid = 1'b1; rx_data = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic tx_take(output logic [7:0] d, output bit ok);
      int c;
      ok = 1'b1; c = 0;
      while (tx_valid !== 1'b1 && c < 20) begin @(negedge clk); c++; end
      if (tx_valid !== 1'b1) begin ok = 1'b0; d = 'x; return; end
      d = tx_data; tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_cmp++;
      if ({awready, wready, arready} !== 3'b111) begin
         n_err++; $display("FAIL reset_ready: got %b want 111", {awready, wready, arready});
      end
      n_cmp++;
      if ({bvalid, rvalid, interrupt, tx_valid} !== 4'b0000) begin
         n_err++; $display("FAIL reset_valid: got %b want 0000", {bvalid, rvalid, interrupt, tx_valid});
      end
      n_cmp++;
      if ({bresp, rresp, rdata, tx_data} !== 44'h0) begin
         n_err++; $display("FAIL reset_data: got %h want 0", {bresp, rresp, rdata, tx_data});
      end
   endtask

   task automatic test_tx_single();
      logic [1:0] resp; bit ok; int held; logic [7:0] d, e;
      axi_write(32'h4, 32'h41, 4'hF, 1, 3, resp, ok, held);
      m_write(32'h4, 32'h41, 4'hF);
      n_cmp++;
      if (!ok || held !== 3) begin
         n_err++; $display("FAIL tx_single_b: ok=%0d bvalid cycles %0d want 3", ok, held);
      end
      n_cmp++;
      if (resp !== 2'b00) begin n_err++; $display("FAIL tx_single_bresp: got %b want 00", resp); end
      n_cmp++;
      if ({awready, wready, bvalid} !== 3'b110) begin
         n_err++; $display("FAIL tx_single_after_b: got %b want 110", {awready, wready, bvalid});
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h41}) begin
         n_err++; $display("FAIL tx_single_hold: got %h want 141", {tx_valid, tx_data});
      end
      tx_take(d, ok);
      e = tx_m.pop_front();
      n_cmp++;
      if (!ok || d !== e) begin n_err++; $display("FAIL tx_single_pop: got %h want %h", d, e); end
      n_cmp++;
      if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_single_empty: got %b want 0", tx_valid); end
   endtask

   task automatic test_rx_basic();
      logic [31:0] addrs [6];
      logic [31:0] d, e; logic [1:0] resp; bit ok;
      addrs = '{32'h8, 32'h0, 32'h0, 32'h0, 32'h8, 32'h4};
      rx_push(8'h5A); m_rx_push(8'h5A);
      rx_push(8'hA5); m_rx_push(8'hA5);
      foreach (addrs[i]) begin
         axi_read(addrs[i], d, resp, ok);
         e = m_read(addrs[i]);
         n_cmp++;
         if (!ok || d !== e || resp !== 2'b00) begin
            n_err++; $display("FAIL rx_basic_read%0d: got %h/%b want %h/00", i, d, resp, e);
         end
      end
   endtask

   task automatic test_overrun();
      logic [31:0] d, e; logic [1:0] resp; bit ok; byte unsigned b;
      for (int i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom); rx_push(b); m_rx_push(b);
      end
      for (int i = 0; i < 2; i++) begin
         axi_read(32'h8, d, resp, ok); e = m_read(32'h8);
         n_cmp++;
         if (!ok || d !== e) begin n_err++; $display("FAIL overrun_stat%0d: got %h want %h", i, d, e); end
      end
      for (int i = 0; i < DEPTH; i++) begin
         axi_read(32'h0, d, resp, ok); e = m_read(32'h0);
         n_cmp++;
         if (!ok || d !== e) begin n_err++; $display("FAIL overrun_drain%0d: got %h want %h", i, d, e); end
      end
   endtask

   task automatic test_tx_overflow();
      logic [1:0] resp; bit ok; int held; logic [31:0] data; logic [7:0] d, e;
      tx_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         data = $urandom;
         axi_write({$urandom} & 32'hFFFF_FFF3 | 32'h4, data, 4'h1, 0, 0, resp, ok, held);
         m_write(32'h4, data, 4'h1);
         n_cmp++;
         if (!ok || resp !== 2'b00) begin
            n_err++; $display("FAIL tx_ovf_bresp%0d: got %b want 00", i, resp);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         tx_take(d, ok); e = tx_m.pop_front();
         n_cmp++;
         if (!ok || d !== e) begin n_err++; $display("FAIL tx_ovf_out%0d: got %h want %h", i, d, e); end
      end
      @(negedge clk);
      n_cmp++;
      if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_ovf_lost: tx_valid %b want 0", tx_valid); end
   endtask

   task automatic test_random();
      logic [31:0] addr, data, d, e; logic [3:0] strb; logic [1:0] resp; bit ok; int held;
      logic [7:0] t, te; byte unsigned b; int irq_base, op;
      irq_base = irq_total;
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 5);
         addr = $urandom;
         case (op)
            0: begin b = 8'($urandom); rx_push(b); m_rx_push(b); end
            1, 2: begin
               if (op == 1) addr[3:2] = 2'd1;
               data = $urandom;
               data[4] = 1'b0;
               if (addr[3:2] == 2'd3 && $urandom_range(0, 3) != 0) data[1:0] = 2'b00;
               strb = 4'($urandom);
               axi_write(addr, data, strb, $urandom_range(0, 1), $urandom_range(0, 2), resp, ok, held);
               m_write(addr, data, strb);
               n_cmp++;
               if (!ok || resp !== 2'b00) begin
                  n_err++; $display("FAIL rand_write%0d: ok=%0d resp %b want 00", i, ok, resp);
               end
            end
            3, 4: begin
               axi_read(addr, d, resp, ok); e = m_read(addr);
               n_cmp++;
               if (!ok || d !== e || resp !== 2'b00) begin
                  n_err++; $display("FAIL rand_read%0d: addr %h got %h want %h", i, addr, d, e);
               end
            end
            default: begin
               if (tx_m.size() != 0) begin
                  tx_take(t, ok); te = tx_m.pop_front();
                  n_cmp++;
                  if (!ok || t !== te) begin n_err++; $display("FAIL rand_tx%0d: got %h want %h", i, t, te); end
               end else begin
                  n_cmp++;
                  if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rand_txe%0d: got %b want 0", i, tx_valid); end
                  @(negedge clk);
               end
            end
         endcase
      end
      axi_read(32'h8, d, resp, ok); e = m_read(32'h8);
      n_cmp++;
      if (!ok || d !== e) begin n_err++; $display("FAIL rand_stat_end: got %h want %h", d, e); end
      n_cmp++;
      if (irq_total - irq_base !== 0) begin
         n_err++; $display("FAIL rand_no_irq: got %0d pulses want 0", irq_total - irq_base);
      end
   endtask

   task automatic test_interrupt();
      logic [1:0] resp; bit ok; int held, base; logic [31:0] d, e; logic [7:0] t, te;
      axi_write(32'hC, 32'h13, 4'h1, 0, 0, resp, ok, held); m_write(32'hC, 32'h13, 4'h1);
      base = irq_total;
      rx_push(8'h77); m_rx_push(8'h77);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (irq_total - base !== 1) begin n_err++; $display("FAIL irq_rx: got %0d pulses want 1", irq_total - base); end
      axi_write(32'h4, 32'h33, 4'h1, 0, 0, resp, ok, held); m_write(32'h4, 32'h33, 4'h1);
      base = irq_total;
      tx_take(t, ok); te = tx_m.pop_front();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (!ok || t !== te || irq_total - base !== 1) begin
         n_err++; $display("FAIL irq_tx: byte %h want %h, %0d pulses want 1", t, te, irq_total - base);
      end
      base = irq_total;
      rx_push(8'h78); m_rx_push(8'h78);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (irq_total - base !== 0) begin n_err++; $display("FAIL irq_rx_nonempty: got %0d want 0", irq_total - base); end
      axi_write(32'hC, 32'h03, 4'h1, 0, 0, resp, ok, held); m_write(32'hC, 32'h03, 4'h1);
      axi_read(32'h8, d, resp, ok); e = m_read(32'h8);
      n_cmp++;
      if (!ok || d !== e) begin n_err++; $display("FAIL irq_ctrl_clear: STAT %h want %h", d, e); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d, e; logic [1:0] resp; bit ok; int c;
      rx_push(8'h11); m_rx_push(8'h11);
      araddr = 32'h8; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0; c = 0;
      while (rvalid !== 1'b1 && c < 20) begin @(negedge clk); c++; end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({rvalid, arready} !== 2'b01) begin
         n_err++; $display("FAIL reset_mid: rvalid/arready got %b want 01", {rvalid, arready});
      end
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      axi_read(32'h8, d, resp, ok); e = m_read(32'h8);
      n_cmp++;
      if (!ok || d !== e) begin n_err++; $display("FAIL reset_mid_stat: got %h want %h", d, e); end
   endtask

   initial begin
      awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_tx_single();
      test_rx_basic();
      test_overrun();
      test_tx_overflow();
      test_random();
      test_interrupt();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
